// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage
//   MEM stage plus the MEM/WB pipeline register. Takes the EX/MEM register
//   outputs and runs data-memory loads and stores over a req/ack bus that may
//   insert wait states. While an access is in flight it stalls the upstream
//   pipeline and feeds bubbles into MEM/WB, so each instruction writes MEM/WB
//   at most once.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   EXMEM_data     {AddrC[68:64], StoreData[63:32], ALUOut[31:0]}
//   EXMEM_control  {MemRead, MemWrite, RegWrite, MemToReg[1:0]}
//   dmem_req       bus request, high only while an access is in flight
//   dmem_we        1 = store, 0 = load (meaningful while dmem_req)
//   dmem_addr      ALUOut, combinational
//   dmem_wdata     StoreData, combinational
//   dmem_ack       access completes this cycle; dmem_rdata valid with it
//   dmem_rdata     load data
//   mem_stall      hold PC/IF/ID/IDEX/EXMEM this cycle (combinational)
//   MEMWB_data     {AddrC, ReadData, ALUOut}
//   MEMWB_control  {RegWrite, MemToReg}
//   mem_err        sticky: misaligned access or bus timeout

module pipeline_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [68:0] EXMEM_data,
  input  logic [4:0]  EXMEM_control,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [68:0] MEMWB_data,
  output logic [2:0]  MEMWB_control,
  output logic        mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last ACCESS cycle index before the access is abandoned.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;

  logic [4:0]  addr_c;
  logic [31:0] store_data;
  logic [31:0] alu_out;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  wb_ctl;
  logic        memop;
  logic        misaligned;

  logic        wb_load;
  logic        err_set;
  logic [31:0] read_data;

  assign addr_c     = EXMEM_data[68:64];
  assign store_data = EXMEM_data[63:32];
  assign alu_out    = EXMEM_data[31:0];
  assign mem_read   = EXMEM_control[4];
  assign mem_write  = EXMEM_control[3];
  assign wb_ctl     = EXMEM_control[2:0];

  assign memop      = mem_read | mem_write;
  assign misaligned = memop & (alu_out[1:0] != 2'b00);

  // The request follows the state register directly, so an asynchronous
  // reset drops it without waiting for a clock edge.
  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = mem_write;
  assign dmem_addr  = alu_out;
  assign dmem_wdata = store_data;

  always_comb begin
    state_n   = state;
    count_n   = count;
    mem_stall = 1'b0;
    wb_load   = 1'b0;
    err_set   = 1'b0;
    read_data = '0;
    case (state)
      IDLE: begin
        if (!memop) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          // Never reaches the bus; flag it and let a bubble through.
          err_set = 1'b1;
        end else begin
          mem_stall = 1'b1;
          count_n   = '0;
          state_n   = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // A combined read+write is treated as a store: no load data.
          wb_load   = 1'b1;
          read_data = (mem_read && !mem_write) ? dmem_rdata : '0;
          state_n   = IDLE;
        end else if (count < LAST) begin
          mem_stall = 1'b1;
          count_n   = count + 1'b1;
        end else begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // MEM -> WB register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      MEMWB_data    <= '0;
      MEMWB_control <= '0;
      mem_err       <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (wb_load) begin
        MEMWB_data    <= {addr_c, read_data, alu_out};
        MEMWB_control <= wb_ctl;
      end else begin
        // Bubble: control cleared, data left as it was.
        MEMWB_control <= '0;
      end
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
module tb_pipeline_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [68:0] EXMEM_data;
  logic [4:0]  EXMEM_control;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [68:0] MEMWB_data;
  logic [2:0]  MEMWB_control;
  logic        mem_err;

  always #5 clk = ~clk;

  pipeline_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .EXMEM_data    (EXMEM_data),
    .EXMEM_control (EXMEM_control),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .mem_stall     (mem_stall),
    .MEMWB_data    (MEMWB_data),
    .MEMWB_control (MEMWB_control),
    .mem_err       (mem_err)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state: what MEM/WB and mem_err must hold right now.
  logic [68:0] m_data;
  logic [2:0]  m_ctl;
  logic        m_err;

  // Expectations for the combinational outputs in the current cycle.
  bit          check_en = 1'b0;
  logic        exp_stall;
  logic        exp_req;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  // Instruction currently presented on EX/MEM.
  logic [4:0]  cur_addrc;
  logic [31:0] cur_alu;
  logic [4:0]  cur_ctl;

  // Observations within one instruction.
  int          req_cnt;
  int          stall_cnt;
  int          nb_cnt;
  logic        we_seen;
  logic [31:0] addr_seen;
  logic [31:0] wdata_seen;

  task automatic cmpv(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      cmpv("mem_stall", {68'd0, mem_stall}, {68'd0, exp_stall});
      cmpv("dmem_req", {68'd0, dmem_req}, {68'd0, exp_req});
      cmpv("MEMWB_data", MEMWB_data, m_data);
      cmpv("MEMWB_control", {66'd0, MEMWB_control}, {66'd0, m_ctl});
      cmpv("mem_err", {68'd0, mem_err}, {68'd0, m_err});
      if (exp_req) begin
        cmpv("dmem_we", {68'd0, dmem_we}, {68'd0, exp_we});
        cmpv("dmem_addr", {37'd0, dmem_addr}, {37'd0, exp_addr});
        cmpv("dmem_wdata", {37'd0, dmem_wdata}, {37'd0, exp_wdata});
      end
    end
  end

  // One clock cycle: state what this cycle must look like and what the
  // coming edge must do to MEM/WB, then advance the model past the edge.
  task automatic step(input logic stall_e, input logic req_e, input logic load_e,
                      input logic [31:0] rd_e, input logic err_e);
    exp_stall = stall_e;
    exp_req   = req_e;
    check_en  = 1'b1;
    @(negedge clk);
    if (dmem_req) begin
      req_cnt++;
      we_seen    = dmem_we;
      addr_seen  = dmem_addr;
      wdata_seen = dmem_wdata;
    end
    if (mem_stall) stall_cnt++;
    @(posedge clk);
    #1;
    if (load_e) begin
      m_data = {cur_addrc, rd_e, cur_alu};
      m_ctl  = cur_ctl[2:0];
    end else begin
      m_ctl = 3'b000;
    end
    if (err_e) m_err = 1'b1;
    if (MEMWB_control != 3'b000) nb_cnt++;
  endtask

  task automatic present(input logic [4:0] ac, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [4:0] ctl);
    cur_addrc     = ac;
    cur_alu       = alu;
    cur_ctl       = ctl;
    EXMEM_data    = {ac, sd, alu};
    EXMEM_control = ctl;
    exp_we        = ctl[3];
    exp_addr      = alu;
    exp_wdata     = sd;
    req_cnt       = 0;
    stall_cnt     = 0;
    nb_cnt        = 0;
    dmem_ack      = 1'b0;
  endtask

  // Runs one instruction to completion. w = number of ACCESS cycles before
  // the bus acks; w >= TIMEOUT means the bus never answers.
  task automatic run_instr(input logic [4:0] ac, input logic [31:0] sd, input logic [31:0] alu,
                           input logic [4:0] ctl, input int w, input logic [31:0] ack_rdata);
    logic rd, wr;
    rd = ctl[4];
    wr = ctl[3];
    present(ac, sd, alu, ctl);
    dmem_rdata = $urandom;
    if (!(rd || wr)) begin
      step(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    end else if (alu[1:0] != 2'b00) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    end else begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      for (int k = 0; k < TIMEOUT; k++) begin
        if (k == w) begin
          dmem_ack   = 1'b1;
          dmem_rdata = ack_rdata;
          step(1'b0, 1'b1, 1'b1, (rd && !wr) ? ack_rdata : 32'd0, 1'b0);
          dmem_ack = 1'b0;
          break;
        end else if (k == TIMEOUT - 1) begin
          dmem_rdata = $urandom;
          step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        end else begin
          dmem_rdata = $urandom;
          step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          kind;
    int          r;
    int          w;
    logic [31:0] alu;
    logic [4:0]  ctl;

    reset         = 1'b1;
    EXMEM_data    = '0;
    EXMEM_control = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    m_data        = '0;
    m_ctl         = '0;
    m_err         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmpv("reset_MEMWB_data", MEMWB_data, 69'd0);
    cmpv("reset_MEMWB_control", {66'd0, MEMWB_control}, 69'd0);
    cmpv("reset_mem_err", {68'd0, mem_err}, 69'd0);
    cmpv("reset_dmem_req", {68'd0, dmem_req}, 69'd0);
    reset = 1'b0;

    // ALU op: one cycle, no stall.
    run_instr(5'd3, 32'd0, 32'h10, 5'b00100, 0, 32'd0);
    cmpv("t1_data", MEMWB_data, {5'd3, 32'd0, 32'h10});
    cmpv("t1_ctl", {66'd0, MEMWB_control}, {66'd0, 3'b100});
    cmpv("t1_stalls", 69'(stall_cnt), 69'd0);

    // Load acked in the second ACCESS cycle.
    run_instr(5'd7, 32'h5555, 32'h40, 5'b10101, 1, 32'hDEADBEEF);
    cmpv("t2_rdata", {37'd0, MEMWB_data[63:32]}, {37'd0, 32'hDEADBEEF});
    cmpv("t2_ctl", {66'd0, MEMWB_control}, {66'd0, 3'b101});
    cmpv("t2_stalls", 69'(stall_cnt), 69'd2);
    cmpv("t2_nonbubble", 69'(nb_cnt), 69'd1);

    // Store with immediate ack.
    run_instr(5'd9, 32'h1234, 32'h80, 5'b01000, 0, 32'hFFFF_FFFF);
    cmpv("t3_we", {68'd0, we_seen}, 69'd1);
    cmpv("t3_addr", {37'd0, addr_seen}, {37'd0, 32'h80});
    cmpv("t3_wdata", {37'd0, wdata_seen}, {37'd0, 32'h1234});
    cmpv("t3_stalls", 69'(stall_cnt), 69'd1);
    cmpv("t3_rdata", {37'd0, MEMWB_data[63:32]}, 69'd0);

    // Load that the bus never acks.
    run_instr(5'd2, 32'd0, 32'h100, 5'b10100, TIMEOUT, 32'd0);
    cmpv("t5_req_cycles", 69'(req_cnt), 69'd16);
    cmpv("t5_stalls", 69'(stall_cnt), 69'd16);
    cmpv("t5_err", {68'd0, mem_err}, 69'd1);
    cmpv("t5_ctl", {66'd0, MEMWB_control}, 69'd0);
    cmpv("t5_nonbubble", 69'(nb_cnt), 69'd0);

    // Reset in the middle of an access.
    present(5'd5, 32'd0, 32'h200, 5'b10100);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    cmpv("t6_req", {68'd0, dmem_req}, 69'd0);
    cmpv("t6_data", MEMWB_data, 69'd0);
    cmpv("t6_ctl", {66'd0, MEMWB_control}, 69'd0);
    cmpv("t6_err", {68'd0, mem_err}, 69'd0);
    EXMEM_data    = '0;
    EXMEM_control = '0;
    m_data        = '0;
    m_ctl         = '0;
    m_err         = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(5'd1, 32'd0, 32'h44, 5'b00110, 0, 32'd0);
    cmpv("t6_idle_ctl", {66'd0, MEMWB_control}, {66'd0, 3'b110});
    cmpv("t6_idle_stalls", 69'(stall_cnt), 69'd0);

    // Misaligned load.
    run_instr(5'd4, 32'd0, 32'h42, 5'b10100, 0, 32'd0);
    cmpv("t4_req_cycles", 69'(req_cnt), 69'd0);
    cmpv("t4_stalls", 69'(stall_cnt), 69'd0);
    cmpv("t4_err", {68'd0, mem_err}, 69'd1);
    cmpv("t4_ctl", {66'd0, MEMWB_control}, 69'd0);

    // Randomized instruction stream; a reset part way through re-arms mem_err.
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        check_en = 1'b0;
        reset    = 1'b1;
        m_data   = '0;
        m_ctl    = '0;
        m_err    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      kind = $urandom_range(0, 3);
      ctl  = {kind[1:0] == 2'd0 ? 2'b00 : kind[1:0] == 2'd1 ? 2'b10 :
              kind[1:0] == 2'd2 ? 2'b01 : 2'b11, 3'($urandom_range(0, 7))};
      alu = $urandom;
      if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r == 0) w = TIMEOUT;
      else if (r == 1) w = TIMEOUT - 1;
      else w = $urandom_range(0, 4);
      run_instr(5'($urandom), $urandom, alu, ctl, w, $urandom);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
